// File: rtl/subtractor_32_seq.sv
// rtl/subtractor_32_seq.sv - multi-cycle chunked subtractor D = A - B - Bin with valid/ready handshakes
// Computes A + ~B + ~Bin one CHUNK per cycle (LS chunk first); flags are registered one cycle after the last chunk.
module subtractor_32_seq #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] D,
   output logic             Bout,
   output logic             OVF,
   output logic             Z
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDXW   = $clog2(NCHUNK + 1);
   localparam int MSB    = WIDTH - 1;

   generate
      if (WIDTH % CHUNK != 0) begin : g_bad_chunk
         $error("subtractor_32_seq: WIDTH must be a multiple of CHUNK");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state_q, state_d;
   logic             rdy_q;
   logic [WIDTH-1:0] a_q, b_q, d_q;
   logic             c_q;
   logic [IDXW-1:0]  idx_q;
   logic             bout_q, ovf_q, z_q;
   logic [CHUNK-1:0] a_chunk, b_chunk;
   logic [CHUNK:0]   sum;
   logic             last;
   logic             accept;

   // Chunk select by comparison against each constant index keeps all part-selects static.
   always_comb begin
      a_chunk = '0;
      b_chunk = '0;
      for (int k = 0; k < NCHUNK; k++) begin
         if (idx_q == IDXW'(k)) begin
            a_chunk = a_q[k*CHUNK +: CHUNK];
            b_chunk = b_q[k*CHUNK +: CHUNK];
         end
      end
      sum  = {1'b0, a_chunk} + {1'b0, ~b_chunk} + {{CHUNK{1'b0}}, c_q};
      last = (idx_q == IDXW'(NCHUNK));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = rdy_q;
            if (in_valid && rdy_q) state_d = CALC;
         end
         CALC: begin
            if (last) state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign accept = in_valid && in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_q  <= 1'b0;
         a_q    <= '0;
         b_q    <= '0;
         d_q    <= '0;
         c_q    <= 1'b0;
         idx_q  <= '0;
         bout_q <= 1'b0;
         ovf_q  <= 1'b0;
         z_q    <= 1'b0;
      end else begin
         rdy_q <= 1'b1;
         if (accept) begin
            a_q   <= A;
            b_q   <= B;
            c_q   <= ~Bin;
            idx_q <= '0;
         end else if (state_q == CALC) begin
            if (!last) begin
               for (int k = 0; k < NCHUNK; k++) begin
                  if (idx_q == IDXW'(k)) d_q[k*CHUNK +: CHUNK] <= sum[CHUNK-1:0];
               end
               c_q   <= sum[CHUNK];
               idx_q <= idx_q + 1'b1;
            end else begin
               // Extra cycle: D is complete, so the flags are taken from registers only.
               bout_q <= ~c_q;
               ovf_q  <= (a_q[MSB] != b_q[MSB]) && (d_q[MSB] != a_q[MSB]);
               z_q    <= (d_q == '0);
            end
         end
      end
   end

   assign D    = d_q;
   assign Bout = bout_q;
   assign OVF  = ovf_q;
   assign Z    = z_q;

endmodule

// File: tb/tb_subtractor_32_seq.sv
// tb/tb_subtractor_32_seq.sv - table, corner-case and random scoreboard bench for subtractor_32_seq
module tb_subtractor_32_seq;

   parameter int CHUNK = 8;
   localparam int LAT = 32 / CHUNK + 1;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        bin;
      logic [31:0] d;
      logic        bout;
      logic        ovf;
      logic        z;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] A, B;
   logic        Bin;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] D;
   logic        Bout, OVF, Z;

   int   errors = 0;
   int   checks = 0;
   vec_t sb[$];
   vec_t tbl[12];

   subtractor_32_seq #(.WIDTH(32), .CHUNK(CHUNK)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .Bin       (Bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .D         (D),
      .Bout      (Bout),
      .OVF       (OVF),
      .Z         (Z)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t ref_sub(input logic [31:0] a, input logic [31:0] b, input logic bin);
      vec_t        v;
      logic [32:0] r;
      r      = {1'b0, a} - {1'b0, b} - {32'b0, bin};
      v.a    = a;
      v.b    = b;
      v.bin  = bin;
      v.d    = r[31:0];
      v.bout = r[32];
      v.ovf  = (a[31] != b[31]) && (r[31] != a[31]);
      v.z    = (r[31:0] == 32'h0);
      return v;
   endfunction

   task automatic do_op(input vec_t v, input int hold);
      int   cyc;
      vec_t e;
      @(negedge clk);
      A = v.a; B = v.b; Bin = v.bin; in_valid = 1'b1;
      cyc = 0;
      while (!in_ready && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      if (!in_ready) begin
         check("accept_timeout", 32'(in_ready), 32'h1);
         in_valid = 1'b0;
         return;
      end
      sb.push_back(v);
      @(posedge clk); #1;
      in_valid = 1'b0; A = $urandom; B = $urandom; Bin = 1'($urandom_range(0, 1));
      cyc = 0;
      while (!out_valid && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
      end
      e = sb.pop_front();
      if (!out_valid) begin
         check("result_timeout", 32'(out_valid), 32'h1);
         return;
      end
      check("latency", 32'(cyc), 32'(LAT));
      check("D", D, e.d);
      check("Bout", 32'(Bout), 32'(e.bout));
      check("OVF", 32'(OVF), 32'(e.ovf));
      check("Z", 32'(Z), 32'(e.z));
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         in_valid = (h == 0);
         A = $urandom; B = $urandom;
         @(posedge clk); #1;
         check("hold_D", D, e.d);
         check("hold_flags", {29'b0, Bout, OVF, Z}, {29'b0, e.bout, e.ovf, e.z});
         check("hold_hs", {30'b0, out_valid, in_ready}, 32'h2);
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("post_hs", {30'b0, out_valid, in_ready}, 32'h1);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      int   sel;
      logic [31:0] corner[4];
      corner[0] = 32'h0; corner[1] = 32'hFFFF_FFFF; corner[2] = 32'h8000_0000; corner[3] = 32'h7FFF_FFFF;

      tbl[0]  = '{32'h5,         32'h3,         1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{32'h0,         32'h1,         1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
      tbl[2]  = '{32'h8000_0000, 32'h1,         1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0};
      tbl[3]  = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1, 1'b0};
      tbl[4]  = '{32'h7,         32'h7,         1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
      tbl[5]  = '{32'h5,         32'h5,         1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
      tbl[6]  = '{32'h8000_0000, 32'h0,         1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0};
      tbl[7]  = '{32'h0,         32'h0,         1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
      tbl[8]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
      tbl[9]  = '{32'h0,         32'h0,         1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
      tbl[10] = '{32'h1234_5678, 32'h0123_4567, 1'b0, 32'h1111_1111, 1'b0, 1'b0, 1'b0};
      tbl[11] = '{32'h0000_0100, 32'h0000_0001, 1'b1, 32'h0000_00FE, 1'b0, 1'b0, 1'b0};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; Bin = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_outputs", {D[27:0], in_ready, out_valid, Bout, OVF}, 32'h0);
      check("rst_Z", 32'(Z), 32'h0);
      rst_n = 1'b1;
      #1;
      check("rdy_before_edge", 32'(in_ready), 32'h0);
      @(posedge clk); #1;
      check("rdy_after_edge", 32'(in_ready), 32'h1);

      foreach (tbl[i]) do_op(tbl[i], 0);

      // Backpressure: hold the result for 10 cycles with a stray in_valid pulse.
      do_op(tbl[3], 10);
      do_op(tbl[4], 0);

      // Reset during the 2nd CALC cycle aborts the operation.
      @(negedge clk);
      A = 32'hDEAD_BEEF; B = 32'h1; Bin = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("abort_D", D, 32'h0);
      check("abort_hs", {28'b0, out_valid, in_ready, Bout, OVF}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (i == 7) check("abort_no_result", 32'(out_valid), 32'h0);
      end
      do_op(ref_sub(32'h9, 32'h4, 1'b0), 0);
      check("after_abort_D", D, 32'h5);

      for (int n = 0; n < 3000; n++) begin
         sel = $urandom_range(0, 9);
         v.a = (sel < 4) ? corner[sel] : $urandom;
         sel = $urandom_range(0, 9);
         v.b = (sel < 4) ? corner[sel] : $urandom;
         if ($urandom_range(0, 15) == 0) v.b = v.a;
         v.bin = 1'($urandom_range(0, 1));
         do_op(ref_sub(v.a, v.b, v.bin), $urandom_range(0, 2));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
